// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the two-requester ROM backdoor arbiter.
package rom_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic REQ_M0 = 1'b0;
  localparam logic REQ_M1 = 1'b1;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 16;
  localparam int unsigned DEFAULT_ADDR_W         = 12;

  function automatic logic [31:0] addr_mask(input int unsigned width);
    if (width >= 32) addr_mask = '1;
    else             addr_mask = (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/rom_wb_arbiter_if.sv
// Bus bundle between two Wishbone requesters, the arbiter and the ROM backdoor.
interface rom_wb_arbiter_if;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [31:0] m0_addr_i, m0_data_i;
  logic [31:0] m0_data_o;
  logic        m0_ack_o, m0_err_o;

  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [31:0] m1_addr_i, m1_data_i;
  logic [31:0] m1_data_o;
  logic        m1_ack_o, m1_err_o;

  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_addr_o, s_data_o;
  logic [31:0] s_data_i;
  logic        s_ack_i;

  logic [1:0]  grant_o;
  logic        timeout_err_o;

  // Arbiter side
  modport slave (
    input  m0_cyc_i, m0_stb_i, m0_we_i, m0_addr_i, m0_data_i,
    output m0_data_o, m0_ack_o, m0_err_o,
    input  m1_cyc_i, m1_stb_i, m1_we_i, m1_addr_i, m1_data_i,
    output m1_data_o, m1_ack_o, m1_err_o,
    output s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_data_o,
    input  s_data_i, s_ack_i,
    output grant_o, timeout_err_o
  );

  // Requesters and ROM side
  modport master (
    output m0_cyc_i, m0_stb_i, m0_we_i, m0_addr_i, m0_data_i,
    input  m0_data_o, m0_ack_o, m0_err_o,
    output m1_cyc_i, m1_stb_i, m1_we_i, m1_addr_i, m1_data_i,
    input  m1_data_o, m1_ack_o, m1_err_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_data_o,
    output s_data_i, s_ack_i,
    input  grant_o, timeout_err_o
  );
endinterface

// File: rtl/rom_arb_timer.sv
// Ownership watchdog: counts clocks while enabled, saturates and flags at LIMIT.
// Only present when ROM_ARB_TIMEOUT_EN is defined.
`ifdef ROM_ARB_TIMEOUT_EN
module rom_arb_timer #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int unsigned    CW      = $clog2(LIMIT + 1);
  localparam logic [CW-1:0]  LIMIT_C = CW'(LIMIT);

  logic [CW-1:0] count_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                        count_q <= '0;
    else if (clear)                      count_q <= '0;
    else if (enable && count_q != LIMIT_C) count_q <= count_q + 1'b1;
  end

  assign expire = (count_q == LIMIT_C);
endmodule
`endif

// File: rtl/rom_wb_arbiter.sv
// Round-robin arbiter giving two Wishbone requesters exclusive use of a ROM backdoor.
// Optional ownership timeout enabled by defining ROM_ARB_TIMEOUT_EN.
module rom_wb_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned ADDR_W         = DEFAULT_ADDR_W,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input logic             clock,
  input logic             reset_n,
  rom_wb_arbiter_if.slave bus
);
  localparam logic [31:0] ADDR_MASK = addr_mask(ADDR_W);

  state_t state_q, state_d;
  logic   last_q, last_d;
  logic   req0, req1, win;
  logic   owner_cyc, expire, timeout_hit, timeout_q;

  assign req0 = bus.m0_cyc_i & bus.m0_stb_i;
  assign req1 = bus.m1_cyc_i & bus.m1_stb_i;

  always_comb begin
    owner_cyc = 1'b0;
    case (state_q)
      OWN0:    owner_cyc = bus.m0_cyc_i;
      OWN1:    owner_cyc = bus.m1_cyc_i;
      default: owner_cyc = 1'b0;
    endcase
  end

  assign timeout_hit = expire & owner_cyc & ~bus.s_ack_i;

`ifdef ROM_ARB_TIMEOUT_EN
  rom_arb_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (state_q == IDLE),
    .enable  (state_q != IDLE),
    .expire  (expire)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) timeout_q <= 1'b0;
    else          timeout_q <= timeout_q | timeout_hit;
  end
`else
  assign expire    = 1'b0;
  assign timeout_q = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q  <= REQ_M1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Every ownership ends in IDLE, so a requester that re-asserts right after
  // its ack is arbitrated afresh against the other one.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    win     = REQ_M0;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          win     = (req0 & req1) ? ~last_q : (req1 ? REQ_M1 : REQ_M0);
          state_d = (win == REQ_M1) ? OWN1 : OWN0;
          last_d  = win;
        end
      end
      OWN0, OWN1: begin
        if (!owner_cyc || bus.s_ack_i || expire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.s_cyc_o   = 1'b0;
    bus.s_stb_o   = 1'b0;
    bus.s_we_o    = 1'b0;
    bus.s_addr_o  = '0;
    bus.s_data_o  = '0;
    bus.m0_data_o = '0;
    bus.m0_ack_o  = 1'b0;
    bus.m0_err_o  = 1'b0;
    bus.m1_data_o = '0;
    bus.m1_ack_o  = 1'b0;
    bus.m1_err_o  = 1'b0;
    bus.grant_o   = 2'b00;
    case (state_q)
      OWN0: begin
        bus.grant_o   = 2'b01;
        bus.s_cyc_o   = bus.m0_cyc_i;
        bus.s_stb_o   = bus.m0_stb_i;
        bus.s_we_o    = bus.m0_we_i;
        bus.s_addr_o  = bus.m0_addr_i & ADDR_MASK;
        bus.s_data_o  = bus.m0_data_i;
        bus.m0_data_o = bus.s_data_i;
        bus.m0_ack_o  = bus.m0_cyc_i & bus.s_ack_i;
        bus.m0_err_o  = timeout_hit;
      end
      OWN1: begin
        bus.grant_o   = 2'b10;
        bus.s_cyc_o   = bus.m1_cyc_i;
        bus.s_stb_o   = bus.m1_stb_i;
        bus.s_we_o    = bus.m1_we_i;
        bus.s_addr_o  = bus.m1_addr_i & ADDR_MASK;
        bus.s_data_o  = bus.m1_data_i;
        bus.m1_data_o = bus.s_data_i;
        bus.m1_ack_o  = bus.m1_cyc_i & bus.s_ack_i;
        bus.m1_err_o  = timeout_hit;
      end
      default: ;
    endcase
  end

  assign bus.timeout_err_o = timeout_q;

endmodule
